// File: rtl/sm_mult_seq_pkg.sv
// Shared constants and state codes for the sign-magnitude sequential multiplier.
package sm_mult_seq_pkg;
  localparam int WIDTH = 8;
  localparam int MAG   = WIDTH - 1;
  localparam int PW    = 2 * MAG;
  localparam int CW    = $clog2(MAG);

  // Code 2'd3 is unused and falls back to IDLE.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/sm_mult_seq_if.sv
// Launch/result bundle between the key-driven top level and the multiplier.
import sm_mult_seq_pkg::*;

interface sm_mult_seq_if;
  // Handshake: start is honoured only while busy=0; done pulses for one cycle
  // when prod_mag/prod_sign/zero become valid, and they hold until the next launch.
  logic             start;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             busy;
  logic             done;
  logic [PW-1:0]    prod_mag;
  logic             prod_sign;
  logic             zero;
  logic [1:0]       dbg_state;

  modport master (
    output start, a_in, b_in,
    input  busy, done, prod_mag, prod_sign, zero, dbg_state
  );

  modport slave (
    input  start, a_in, b_in,
    output busy, done, prod_mag, prod_sign, zero, dbg_state
  );
endinterface

// File: rtl/fulladder_8bit.sv
// 8-bit ripple-carry adder built from a chain of full-adder cells.
module fulladder_8bit (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       ci,
  output logic [7:0] s,
  output logic       co
);
  logic [8:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < 8; i++) begin : g_bit
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign co = c[8];
endmodule

// File: rtl/sm_mult_seq.sv
// Shift-add sign-magnitude multiplier: one partial product per clock through
// the shared ripple adder, with a start/busy/done handshake.
module sm_mult_seq
  import sm_mult_seq_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  sm_mult_seq_if.slave bus
);
  state_t           state_q, state_d;
  logic [MAG-1:0]   mcand_q, mplier_q, acc_q;
  logic             sgn_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q, done_q, sign_q, zero_q;
  logic [PW-1:0]    prod_q;

  logic [WIDTH-1:0] add_a, add_b, add_s;
  logic             unused_co;
  logic [MAG-1:0]   acc_next, mplier_next;
  logic [PW-1:0]    product;
  logic             prod_is_zero, last_iter;
  logic             accept, busy_d, done_d;

  // acc and mcand are both below 2^MAG, so the sum always fits in WIDTH bits.
  assign add_a = {1'b0, acc_q};
  assign add_b = mplier_q[0] ? {1'b0, mcand_q} : '0;

  fulladder_8bit u_adder (
    .a  (add_a),
    .b  (add_b),
    .ci (1'b0),
    .s  (add_s),
    .co (unused_co)
  );

  assign acc_next     = add_s[WIDTH-1:1];
  assign mplier_next  = {add_s[0], mplier_q[MAG-1:1]};
  assign product      = {acc_next, mplier_next};
  assign prod_is_zero = (product == '0);
  assign last_iter    = (cnt_q == CW'(MAG - 1));

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (last_iter) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    accept = 1'b0;
    busy_d = 1'b0;
    done_d = 1'b0;
    accept = (state_q == IDLE) && bus.start;
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      sgn_q    <= 1'b0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      prod_q   <= '0;
      sign_q   <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      busy_q <= busy_d;
      done_q <= done_d;
      if (accept) begin
        mcand_q  <= bus.a_in[MAG-1:0];
        mplier_q <= bus.b_in[MAG-1:0];
        sgn_q    <= bus.a_in[MAG] ^ bus.b_in[MAG];
        acc_q    <= '0;
        cnt_q    <= '0;
      end else if (state_q == RUN) begin
        acc_q    <= acc_next;
        mplier_q <= mplier_next;
        cnt_q    <= cnt_q + CW'(1);
        if (last_iter) begin
          prod_q <= product;
          zero_q <= prod_is_zero;
          // Negative zero is reported as +0.
          sign_q <= sgn_q & ~prod_is_zero;
        end
      end
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.prod_mag  = prod_q;
  assign bus.prod_sign = sign_q;
  assign bus.zero      = zero_q;
  assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_sm_mult_seq.sv
// Directed bench for sm_mult_seq: cycle model from arithmetic plus literal result pins.
module tb_sm_mult_seq;
  import sm_mult_seq_pkg::*;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sm_mult_seq_if bus ();

  sm_mult_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;
  int done_seen = 0;
  bit checking = 1'b0;
  logic [15:0] exp_q[$];

  // behavioural model: countdown of cycles left in the busy window
  int          m_rem;
  int          pend_mag;
  logic        pend_sign;
  logic [13:0] m_mag;
  logic        m_sign;
  logic        m_zero;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_rem  = 0;
      m_mag  = '0;
      m_sign = 1'b0;
      m_zero = 1'b0;
    end else if (m_rem == 0) begin
      if (bus.start) begin
        m_rem     = MAG + 1;
        pend_mag  = int'(bus.a_in[6:0]) * int'(bus.b_in[6:0]);
        pend_sign = (bus.a_in[7] ^ bus.b_in[7]) && (pend_mag != 0);
      end
    end else begin
      m_rem = m_rem - 1;
      if (m_rem == 1) begin
        m_mag  = 14'(pend_mag);
        m_sign = pend_sign;
        m_zero = (pend_mag == 0);
      end
    end
  end

  // compare process + scoreboard
  always @(negedge clk) begin
    if (checking) begin
      chk("busy",      bus.busy,      m_rem > 0);
      chk("done",      bus.done,      m_rem == 1);
      chk("prod_mag",  bus.prod_mag,  m_mag);
      chk("prod_sign", bus.prod_sign, m_sign);
      chk("zero",      bus.zero,      m_zero);
      if (bus.done) begin
        done_seen++;
        if (exp_q.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          logic [15:0] e;
          e = exp_q.pop_front();
          chk("lit_result", {bus.prod_sign, bus.zero, bus.prod_mag}, e);
        end
      end
    end
  end

  // driver tasks
  task automatic launch(input logic [7:0] a, input logic [7:0] b, input logic [15:0] e, input bit push);
    bus.a_in  = a;
    bus.b_in  = b;
    bus.start = 1'b1;
    if (push) exp_q.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
    bus.a_in  = 8'($urandom_range(0, 255));
    bus.b_in  = 8'($urandom_range(0, 255));
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!bus.done && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("done_timeout", 1, 0);
  endtask

  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [15:0] e);
    int n;
    launch(a, b, e, 1'b1);
    wait_done(n);
    chk("latency", n, 7);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    int d0;
    int n;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a_in  = '0;
    bus.b_in  = '0;
    repeat (2) @(negedge clk);
    checking = 1'b1;
    chk("rst_busy", bus.busy, 0);
    chk("rst_prod", bus.prod_mag, 0);
    chk("rst_zero", bus.zero, 0);
    rst = 1'b0;
    @(negedge clk);

    run_op(8'h05, 8'h03, {1'b0, 1'b0, 14'd15});
    run_op(8'hFF, 8'h7F, {1'b1, 1'b0, 14'h3F01});
    run_op(8'h8C, 8'h8A, {1'b0, 1'b0, 14'd120});
    run_op(8'h80, 8'h85, {1'b0, 1'b1, 14'd0});
    run_op(8'h7F, 8'h01, {1'b0, 1'b0, 14'd127});
    run_op(8'h01, 8'h81, {1'b1, 1'b0, 14'd1});
    run_op(8'h00, 8'h00, {1'b0, 1'b1, 14'd0});

    // start while busy is ignored
    d0 = done_seen;
    launch(8'h07, 8'h06, {1'b0, 1'b0, 14'd42}, 1'b1);
    repeat (2) @(negedge clk);
    bus.a_in  = 8'h7F;
    bus.b_in  = 8'h7F;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(n);
    repeat (12) @(negedge clk);
    chk("one_done", done_seen - d0, 1);

    // reset in the middle of RUN discards the operation
    d0 = done_seen;
    launch(8'h12, 8'h83, 16'h0, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_done", bus.done, 0);
    chk("midrst_prod", bus.prod_mag, 0);
    chk("midrst_sign", bus.prod_sign, 0);
    repeat (12) @(negedge clk);
    chk("midrst_no_done", done_seen - d0, 0);
    run_op(8'h85, 8'h09, {1'b1, 1'b0, 14'd45});

    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sm_mult_seq.md
Name: sm_mult_seq

Overview:
Sequential sign-magnitude multiplier controller for the board lab datapath.
- Operands are 8-bit sign-magnitude words from the switches: bit 7 is the sign, bits 6:0 are the magnitude.
- It sequences the existing 8-bit ripple adder (fulladder_8bit) through a shift-add loop, one partial product per clock.
- It produces a 14-bit magnitude product plus a sign, for the HEX display logic.
- It has a start/busy/done handshake so the key-driven top level can launch an operation and latch the result.

Parameters:
- WIDTH, 8, operand width including the sign bit; magnitude width MAG = WIDTH-1.
- Product magnitude width is 2*MAG (14 at default).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  launch request; sampled only in IDLE.
- a_in  in  WIDTH  operand A, sign-magnitude.
- b_in  in  WIDTH  operand B, sign-magnitude.
- busy  out  1  high in RUN and DONE.
- done  out  1  one-cycle pulse; result valid.
- prod_mag  out  2*MAG  product magnitude; held until the next accepted start.
- prod_sign  out  1  product sign; 1 means negative; never 1 when prod_mag is 0.
- zero  out  1  prod_mag == 0; registered with the result.

Behaviour:
- Reset: clk is the only clock; rst is synchronous and active-high. On any rising clk edge with rst=1:
  - state goes to IDLE;
  - busy, done, prod_mag, prod_sign and zero all go to 0;
  - internal registers and the iteration counter clear.
- rst overrides every other input, including mid-RUN; an in-flight operation is discarded with no done pulse.
- States and transitions: IDLE -> RUN -> DONE -> IDLE.
- IDLE, start=1 at an edge:
  - mcand <= a_in[MAG-1:0];
  - mplier <= b_in[MAG-1:0];
  - sgn <= a_in[MAG] ^ b_in[MAG];
  - acc <= 0 (MAG bits);
  - cnt <= 0;
  - go to RUN.
- IDLE, start=0: hold state and outputs.
- RUN, each cycle:
  - adder A = {1'b0, acc}, adder B = mplier[0] ? {1'b0, mcand} : 0, ci = 0;
  - acc <= S[WIDTH-1:1] and mplier <= {S[0], mplier[MAG-1:1]} (right shift of {S, mplier});
  - cnt increments.
- RUN, last iteration: when cnt == MAG-1, the edge instead moves to DONE and loads the outputs:
  - prod_mag <= {acc_next, mplier_next};
  - zero <= (product == 0);
  - prod_sign <= sgn & ~(product == 0), so negative zero is normalised to +0.
- DONE: done=1 for exactly this cycle; next edge goes to IDLE.
- Latency: start edge T gives RUN during cycles T+1..T+MAG (7 cycles) and DONE in cycle T+MAG+1 (T+8). Minimum launch-to-launch period is MAG+2 = 9 cycles.
- start while busy=1 is ignored; it is neither queued nor sticky.
- Operands are sampled only at the accepting edge; later changes to a_in/b_in have no effect.
- Width: the adder sum never exceeds 2^WIDTH-1 because acc and mcand are each at most 2^MAG-1, so no carry out of the adder is used. No overflow is possible.
- Outputs are fully registered; no combinational path from inputs to outputs.

Decomposition:
- Shared defines file holds:
  - WIDTH and derived MAG;
  - state codes IDLE=2'd0, RUN=2'd1, DONE=2'd2. Code 2'd3 is illegal and recovers to IDLE on the next edge.
- Sub-module: instantiate the existing fulladder_8bit as the datapath adder. No new sub-module; the controller FSM and shift registers stay in sm_mult_seq.

Test Plan:
- Basic multiply: rst 1 cycle; a_in=8'h05, b_in=8'h03, start 1 cycle -> busy high 8 cycles; done at cycle 8 after start; prod_mag=14'd15, prod_sign=0, zero=0.
- Largest product: a_in=8'hFF (-127), b_in=8'h7F (+127) -> prod_mag=14'h3F01 (16129), prod_sign=1.
- Both negative: a_in=8'h8C (-12), b_in=8'h8A (-10) -> prod_mag=14'd120, prod_sign=0.
- Negative zero: a_in=8'h80 (-0), b_in=8'h85 (-5) -> prod_mag=0, zero=1, prod_sign=0.
- Start while busy: start asserted again 3 cycles after launch with different operands -> ignored; first result unchanged; exactly one done pulse.
- Reset mid-run: rst=1 at cycle 4 of RUN -> next edge busy=0, all outputs 0, no done. A fresh start then completes normally.
